// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle for fetch_queue
//
// Purpose : groups the fetch-side push channel, the decode-side pop channel,
//           the branch-redirect flush and the occupancy count.
// Ports   : parameter DEPTH sizes count ($clog2(DEPTH)+1 bits).
//           in_valid/in_pc/in_instr/in_ready : fetch -> queue push channel
//           out_valid/out_pc/out_pc_plus4/out_instr/out_ready : queue -> decode
//           flush : discard all entries; count : current occupancy
// Modports: master = fetch/decode side, slave = the queue itself.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic [63:0]              in_pc;
  logic [31:0]              in_instr;
  logic                     in_ready;
  logic                     flush;
  logic                     out_valid;
  logic [63:0]              out_pc;
  logic [63:0]              out_pc_plus4;
  logic [31:0]              out_instr;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_pc_plus4, out_instr, count
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_plus4, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between fetch and decode
//
// Purpose : DEPTH-entry FIFO of {pc, instr} with flush and occupancy count.
//           Optional macro FETCH_QUEUE_BYPASS_EN enables empty-queue bypass:
//           an entry offered to an empty queue is presented to decode in the
//           same cycle and only stored if decode does not take it.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset
//           q    - fetch_queue_if.slave (push channel, pop channel, flush, count)
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  fetch_queue_if.slave       q
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  // Entry storage carries no reset; occupancy alone decides what is visible.
  logic [63:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_occ;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic [63:0]   w_pc;
  logic [31:0]   w_instr;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_occ  = (r_count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass = ~w_occ & q.in_valid & ~q.flush;
  assign w_valid  = (w_occ & ~q.flush) | w_bypass;
  // A bypassed entry taken by decode this cycle is never written.
  assign w_push   = q.in_valid & ~w_full & ~q.flush & ~(w_bypass & q.out_ready);
  // Storage is only popped when it actually holds the head entry.
  assign w_pop    = w_occ & ~q.flush & q.out_ready;
  assign w_pc     = w_bypass ? q.in_pc    : r_mem_pc[r_rd_ptr];
  assign w_instr  = w_bypass ? q.in_instr : r_mem_instr[r_rd_ptr];
`else
  assign w_valid  = w_occ & ~q.flush;
  assign w_push   = q.in_valid & ~w_full & ~q.flush;
  assign w_pop    = w_valid & q.out_ready;
  assign w_pc     = r_mem_pc[r_rd_ptr];
  assign w_instr  = r_mem_instr[r_rd_ptr];
`endif

  assign q.in_ready     = ~w_full;
  assign q.out_valid    = w_valid;
  assign q.out_pc       = w_valid ? w_pc : 64'd0;
  assign q.out_instr    = w_valid ? w_instr : 32'd0;
  assign q.out_pc_plus4 = w_valid ? (w_pc + 64'd4) : 64'd0;
  assign q.count        = r_count;

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem_pc[r_wr_ptr]    <= q.in_pc;
      r_mem_instr[r_wr_ptr] <= q.in_instr;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard testbench for fetch_queue
module tb_fetch_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  ent_t exp_q[$];
  int   m_cnt = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_bypass();
`ifdef FETCH_QUEUE_BYPASS_EN
    return (m_cnt == 0) && bus.in_valid && !bus.flush;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: checks handshake outputs and pops the scoreboard on DUT pops.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      bit byp;
      bit ev;
      byp = model_bypass();
      ev  = ((m_cnt != 0) && !bus.flush) || byp;
      chk("out_valid", {63'd0, bus.out_valid}, {63'd0, ev});
      chk("in_ready", {63'd0, bus.in_ready}, {63'd0, (m_cnt != DEPTH)});
      chk("count", 64'(bus.count), 64'(m_cnt));
      if (!ev) begin
        chk("idle_pc", bus.out_pc, 64'd0);
        chk("idle_pc4", bus.out_pc_plus4, 64'd0);
        chk("idle_instr", 64'(bus.out_instr), 64'd0);
      end else if (byp) begin
        chk("byp_pc", bus.out_pc, bus.in_pc);
        chk("byp_pc4", bus.out_pc_plus4, bus.in_pc + 64'd4);
        chk("byp_instr", 64'(bus.out_instr), 64'(bus.in_instr));
      end else if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        chk("head_pc", bus.out_pc, exp_q[0].pc);
        chk("head_pc4", bus.out_pc_plus4, exp_q[0].pc + 64'd4);
        chk("head_instr", 64'(bus.out_instr), 64'(exp_q[0].instr));
        if (bus.out_valid && bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Drive one cycle of inputs, then update the reference model at the edge.
  task automatic step(input bit v, input logic [63:0] pc, input logic [31:0] ins,
                      input bit rdy, input bit fl, input bit rs);
    bit push_ok;
    bit pop_ok;
    ent_t e;
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = rdy;
    bus.flush     = fl;
    rst           = rs;
    @(posedge clk);
    push_ok = v && (m_cnt != DEPTH) && !fl;
    pop_ok  = (m_cnt != 0) && !fl && rdy;
    if (model_bypass() && rdy) push_ok = 1'b0;
    if (rs || fl) begin
      m_cnt = 0;
      exp_q.delete();
    end else begin
      if (push_ok) begin
        e.pc    = pc;
        e.instr = ins;
        exp_q.push_back(e);
      end
      m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
    end
    #1;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 32'd0, rdy, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [63:0] pc, input bit rdy);
    step(1'b1, pc, 32'h1300_0000 | 32'(pc[15:0]), rdy, 1'b0, 1'b0);
  endtask

  initial begin
    step(1'b1, 64'h55, 32'h1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1);

    // single push, visible next cycle
    step(1'b1, 64'h0, 32'h8B020020, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1);
    chk("first_pc4", bus.out_pc_plus4, 64'h4);
    chk("first_instr", 64'(bus.out_instr), 64'h8B020020);
    idle(1'b1, 2);

    // fill to full, fifth push dropped, drain in order
    for (int i = 0; i < 5; i++) push(64'(i * 4), 1'b0);
    idle(1'b1, 6);

    // full queue: push refused while head pops
    for (int i = 0; i < 4; i++) push(64'h100 + 64'(i * 4), 1'b0);
    push(64'h200, 1'b1);
    idle(1'b0, 1);
    idle(1'b1, 4);

    // flush with 3 entries and a concurrent push
    for (int i = 0; i < 3; i++) push(64'h300 + 64'(i * 4), 1'b0);
    step(1'b1, 64'h400, 32'h4, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 2);

    // continuous streaming across pointer wrap
    for (int i = 0; i < 10; i++) push(64'(i * 4), 1'b1);
    idle(1'b1, 2);

    // reset mid-operation with 2 entries and a concurrent push
    push(64'h500, 1'b0);
    push(64'h504, 1'b0);
    step(1'b1, 64'h508, 32'h8, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1);
    chk("post_rst_pc", bus.out_pc, 64'd0);
    idle(1'b1, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) != 0, {$urandom, $urandom & 32'hFFFF_FFFC},
           $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 127) == 0);
    end
    idle(1'b1, 6);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  in  1  fetch stage presents an entry.
REQ-005 SHALL have port: in_pc  in  64  address of the fetched instruction.
REQ-006 SHALL have port: in_instr  in  32  fetched instruction word.
REQ-007 SHALL have port: in_ready  out  1  queue accepts an entry this cycle.
REQ-008 SHALL have port: flush  in  1  branch redirect; discard all entries.
REQ-009 SHALL have port: out_valid  out  1  head entry available to decode.
REQ-010 SHALL have port: out_pc  out  64  head entry address.
REQ-011 SHALL have port: out_pc_plus4  out  64  head entry address + 4, for link-register writes.
REQ-012 SHALL have port: out_instr  out  32  head entry instruction.
REQ-013 SHALL have port: out_ready  in  1  decode consumes the head entry this cycle.
REQ-014 SHALL have port: count  out  clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Push SHALL occur when in_valid & in_ready & !flush; entry {in_pc, in_instr} is written at the tail.
REQ-016 Pop SHALL occur when out_valid & out_ready; head pointer advances.
REQ-017 in_ready SHALL equal (count != DEPTH); a full queue SHALL refuse a push even when a pop happens in the same cycle.
REQ-018 out_valid SHALL equal (count != 0) & !flush.
REQ-019 out_pc, out_instr and out_pc_plus4 SHALL be 0 whenever out_valid is 0.
REQ-020 out_pc_plus4 SHALL be out_pc + 4 modulo 2^64 when out_valid is 1.
REQ-021 Entries SHALL leave in strict push order (FIFO).
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; count SHALL change by +1 (push only), -1 (pop only), or 0 (both or neither).
REQ-023 flush SHALL take priority: on the next edge count, read and write pointers become 0; any push or pop in the flush cycle is discarded.
REQ-024 Without bypass, latency from accepted push to out_valid SHALL be exactly 1 cycle.
REQ-025 Storage contents SHALL NOT influence outputs while their entry is not occupied.

Reset
REQ-026 On a rising clk edge with rst=1, count, read pointer and write pointer SHALL become 0, regardless of in_valid, out_ready or flush.
REQ-027 After reset, out_valid=0, in_ready=1, out_pc=0, out_pc_plus4=0, out_instr=0, count=0.
REQ-028 Entry storage SHALL NOT require reset.
REQ-029 rst asserted mid-operation SHALL discard all occupied entries in one cycle.

Configuration
REQ-030 Macro FETCH_QUEUE_BYPASS_EN SHALL enable empty-queue bypass.
REQ-031 With FETCH_QUEUE_BYPASS_EN defined: when count=0, in_valid=1 and flush=0, out_valid SHALL be 1 in the same cycle with out_pc=in_pc, out_instr=in_instr; if out_ready=1 the entry SHALL be consumed without being written (count stays 0), otherwise it SHALL be written (count becomes 1).
REQ-032 Without FETCH_QUEUE_BYPASS_EN: no combinational path from in_* to out_*; REQ-024 latency applies.

Verification (DEPTH=4, bypass off unless stated)
REQ-033 Reset, push in_pc=0x0 in_instr=0x8B020020 -> next cycle out_valid=1, out_pc=0x0, out_pc_plus4=0x4, out_instr=0x8B020020, count=1.
REQ-034 out_ready=0, push pcs 0x0,0x4,0x8,0xC then a fifth 0x10 -> count=4, in_ready=0, 0x10 dropped; then out_ready=1 yields 0x0,0x4,0x8,0xC in order, then out_valid=0.
REQ-035 Full queue, in_valid=1 and out_ready=1 same cycle -> pop of head, push refused, count=3 next cycle.
REQ-036 3 entries, flush=1 with in_valid=1 -> out_valid=0 that cycle; next cycle count=0, out_valid=0, out_pc=0, in_ready=1.
REQ-037 Continuous push/pop of pcs 0x0..0x24 step 4 with out_ready=1 -> order preserved across pointer wrap, count never exceeds 1; with FETCH_QUEUE_BYPASS_EN out_pc equals in_pc same cycle and count stays 0.
REQ-038 2 entries, rst=1 for one cycle with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, pushed entry dropped.
